// File: rtl/spi_ram_pkg.sv
// Shared widths, state encoding and port identifiers for the SPI RAM front end.
package spi_ram_pkg;

    localparam int SPI_ADDR_W = 16;
    localparam int SPI_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } arb_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// One requester port: request handshake plus per-port completion status.
interface spi_ram_arbiter_if #(
    parameter int ADDR_W = spi_ram_pkg::SPI_ADDR_W,
    parameter int DATA_W = spi_ram_pkg::SPI_DATA_W
);
    logic              valid;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rsp_valid;
    logic              rsp_err;

    modport master (output valid, write, addr, wdata, input ready, rsp_valid, rsp_err);
    modport slave  (input valid, write, addr, wdata, output ready, rsp_valid, rsp_err);
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin select; on a tie the port that was not granted last wins.
module rr_arb2 import spi_ram_pkg::*; (
    input  logic valid_a,
    input  logic valid_b,
    input  logic last_grant,
    input  logic enable,
    output logic grant_a,
    output logic grant_b
);

    // Grant selection, gated by enable
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (enable) begin
            if (valid_a && valid_b) begin
                if (last_grant == PORT_B) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else begin
                grant_a = valid_a;
                grant_b = valid_b;
            end
        end else begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter and sequencer sharing one spi_ram_controller between two requesters.
module spi_ram_arbiter import spi_ram_pkg::*; #(
    parameter int ADDR_W     = SPI_ADDR_W,
    parameter int DATA_W     = SPI_DATA_W,
    parameter int START_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    spi_ram_arbiter_if.slave  a_port,
    spi_ram_arbiter_if.slave  b_port,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [DATA_W-1:0] ctrl_wdata,
    output logic              ctrl_start_read,
    output logic              ctrl_start_write,
    input  logic [DATA_W-1:0] ctrl_rdata,
    input  logic              ctrl_busy
);

    localparam int              CNT_W    = $clog2(START_WAIT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    arb_state_t        state_r;
    logic              last_grant_r;
    logic              port_r;
    logic              write_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;
    logic              start_read_r;
    logic              start_write_r;
    logic              a_rsp_valid_r;
    logic              b_rsp_valid_r;
    logic              a_rsp_err_r;
    logic              b_rsp_err_r;

    logic              arb_en_s;
    logic              grant_a_s;
    logic              grant_b_s;
    logic              xfer_a_s;
    logic              xfer_b_s;
    logic [CNT_W-1:0]  cnt_next_s;

    // The controller keeps running across our reset, so never grant while it is busy
    assign arb_en_s = (state_r == IDLE) && !ctrl_busy;
    assign xfer_a_s = a_port.valid && grant_a_s;
    assign xfer_b_s = b_port.valid && grant_b_s;

    rr_arb2 u_rr_arb2 (
        .valid_a    (a_port.valid),
        .valid_b    (b_port.valid),
        .last_grant (last_grant_r),
        .enable     (arb_en_s),
        .grant_a    (grant_a_s),
        .grant_b    (grant_b_s)
    );

    // Saturating increment of the start-wait counter
    always_comb begin
        cnt_next_s = cnt_r;
        if (cnt_r == CNT_MAX) begin
            cnt_next_s = cnt_r;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Sequencer FSM with latched request and registered controller/response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            last_grant_r  <= PORT_B;
            port_r        <= PORT_A;
            write_r       <= 1'b0;
            cnt_r         <= {CNT_W{1'b0}};
            addr_r        <= {ADDR_W{1'b0}};
            wdata_r       <= {DATA_W{1'b0}};
            rdata_r       <= {DATA_W{1'b0}};
            start_read_r  <= 1'b0;
            start_write_r <= 1'b0;
            a_rsp_valid_r <= 1'b0;
            b_rsp_valid_r <= 1'b0;
            a_rsp_err_r   <= 1'b0;
            b_rsp_err_r   <= 1'b0;
        end else begin
            start_read_r  <= 1'b0;
            start_write_r <= 1'b0;
            a_rsp_valid_r <= 1'b0;
            b_rsp_valid_r <= 1'b0;
            a_rsp_err_r   <= 1'b0;
            b_rsp_err_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (xfer_a_s) begin
                        addr_r        <= a_port.addr;
                        wdata_r       <= a_port.wdata;
                        write_r       <= a_port.write;
                        port_r        <= PORT_A;
                        start_read_r  <= !a_port.write;
                        start_write_r <= a_port.write;
                        state_r       <= ISSUE;
                    end else if (xfer_b_s) begin
                        addr_r        <= b_port.addr;
                        wdata_r       <= b_port.wdata;
                        write_r       <= b_port.write;
                        port_r        <= PORT_B;
                        start_read_r  <= !b_port.write;
                        start_write_r <= b_port.write;
                        state_r       <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (ctrl_busy) begin
                        state_r <= WAIT_DONE;
                    end else if (cnt_next_s == CNT_LAST) begin
                        rdata_r       <= {DATA_W{1'b0}};
                        a_rsp_valid_r <= (port_r == PORT_A);
                        b_rsp_valid_r <= (port_r == PORT_B);
                        a_rsp_err_r   <= (port_r == PORT_A);
                        b_rsp_err_r   <= (port_r == PORT_B);
                        state_r       <= RESP;
                    end else begin
                        cnt_r <= cnt_next_s;
                    end
                end
                WAIT_DONE: begin
                    if (!ctrl_busy) begin
                        rdata_r       <= write_r ? {DATA_W{1'b0}} : ctrl_rdata;
                        a_rsp_valid_r <= (port_r == PORT_A);
                        b_rsp_valid_r <= (port_r == PORT_B);
                        state_r       <= RESP;
                    end else begin
                        state_r <= WAIT_DONE;
                    end
                end
                RESP: begin
                    last_grant_r <= port_r;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign a_port.ready     = grant_a_s;
    assign b_port.ready     = grant_b_s;
    assign a_port.rsp_valid = a_rsp_valid_r;
    assign b_port.rsp_valid = b_rsp_valid_r;
    assign a_port.rsp_err   = a_rsp_err_r;
    assign b_port.rsp_err   = b_rsp_err_r;
    assign rsp_rdata        = rdata_r;
    assign ctrl_addr        = addr_r;
    assign ctrl_wdata       = wdata_r;
    assign ctrl_start_read  = start_read_r;
    assign ctrl_start_write = start_write_r;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a simple busy/data model of the SPI RAM controller.
module tb_spi_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rsp_rdata;
    logic [15:0] ctrl_addr;
    logic [31:0] ctrl_wdata;
    logic        ctrl_start_read;
    logic        ctrl_start_write;
    logic [31:0] ctrl_rdata;
    logic        ctrl_busy;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    int          busy_len = 40;
    bit          model_dead = 1'b0;
    bit          force_busy = 1'b0;
    int          busy_cnt = 0;
    int          both_cnt = 0;
    int          a_rsp_cnt = 0;

    spi_ram_arbiter_if #(.ADDR_W(16), .DATA_W(32)) a_if ();
    spi_ram_arbiter_if #(.ADDR_W(16), .DATA_W(32)) b_if ();

    spi_ram_arbiter #(.ADDR_W(16), .DATA_W(32), .START_WAIT(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .a_port           (a_if),
        .b_port           (b_if),
        .rsp_rdata        (rsp_rdata),
        .ctrl_addr        (ctrl_addr),
        .ctrl_wdata       (ctrl_wdata),
        .ctrl_start_read  (ctrl_start_read),
        .ctrl_start_write (ctrl_start_write),
        .ctrl_rdata       (ctrl_rdata),
        .ctrl_busy        (ctrl_busy)
    );

    always #5 clk = ~clk;

    // Controller model: busy rises the cycle after a start pulse and stays up busy_len cycles
    assign ctrl_busy  = force_busy || (busy_cnt != 0);
    assign ctrl_rdata = 32'hDEAD_BEEF;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ((ctrl_start_read || ctrl_start_write) && !model_dead) begin
            busy_cnt <= busy_len;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (a_if.rsp_valid && b_if.rsp_valid) both_cnt <= both_cnt + 1;
        if (a_if.rsp_valid) a_rsp_cnt <= a_rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit p, input bit v, input bit wr, input logic [15:0] ad,
                           input logic [31:0] wd);
        if (p) begin
            b_if.valid = v; b_if.write = wr; b_if.addr = ad; b_if.wdata = wd;
        end else begin
            a_if.valid = v; a_if.write = wr; a_if.addr = ad; a_if.wdata = wd;
        end
    endtask

    function automatic logic get_ready(input bit p);
        return p ? b_if.ready : a_if.ready;
    endfunction

    function automatic logic get_rsp(input bit p);
        return p ? b_if.rsp_valid : a_if.rsp_valid;
    endfunction

    function automatic logic get_err(input bit p);
        return p ? b_if.rsp_err : a_if.rsp_err;
    endfunction

    // Present a request, wait for ready, return the transfer cycle; leaves time at transfer+1
    task automatic drive_req(input bit p, input bit wr, input logic [15:0] ad,
                             input logic [31:0] wd, output int t);
        t = -1;
        set_req(p, 1'b1, wr, ad, wd);
        #1;
        for (int i = 0; i < 200; i++) begin
            if (get_ready(p)) begin
                t = cyc;
                break;
            end
            step();
        end
        if (t < 0) check("ready_timeout", 64'd0, 64'd1);
        step();
        set_req(p, 1'b0, wr, ad, wd);
    endtask

    task automatic wait_rsp(input bit p, input int max, output int t);
        t = -1;
        for (int i = 0; i < max; i++) begin
            if (get_rsp(p)) begin
                t = cyc;
                break;
            end
            step();
        end
        if (t < 0) check("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_start(input int max, output int t);
        t = -1;
        for (int i = 0; i < max; i++) begin
            if (ctrl_start_read || ctrl_start_write) begin
                t = cyc;
                break;
            end
            step();
        end
        if (t < 0) check("start_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int t_x;
        int t_s;
        int t_r;
        int viol;
        int a_snap;
        bit fell;
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_x;
        int t_s;
        int t_r;
        int viol;
        int a_snap;
        bit fell;

        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 16'h0000, 32'h0000_0000);
        set_req(1'b1, 1'b0, 1'b0, 16'h0000, 32'h0000_0000);
        repeat (3) step();
        check("rst_start_read",  {63'd0, ctrl_start_read},  64'd0);
        check("rst_start_write", {63'd0, ctrl_start_write}, 64'd0);
        check("rst_ctrl_addr",   {48'd0, ctrl_addr},        64'd0);
        check("rst_ctrl_wdata",  {32'd0, ctrl_wdata},       64'd0);
        check("rst_rsp_rdata",   {32'd0, rsp_rdata},        64'd0);
        check("rst_rsp_valid",   {62'd0, a_if.rsp_valid, b_if.rsp_valid}, 64'd0);
        rst = 1'b0;
        step();

        // Single read on A
        busy_len = 40;
        drive_req(1'b0, 1'b0, 16'h0010, 32'h0000_0000, t_x);
        check("rd_start_read",  {63'd0, ctrl_start_read},  64'd1);
        check("rd_start_write", {63'd0, ctrl_start_write}, 64'd0);
        check("rd_ctrl_addr",   {48'd0, ctrl_addr},        64'h0010);
        step();
        check("rd_pulse_width", {63'd0, ctrl_start_read},  64'd0);
        wait_rsp(1'b0, 100, t_r);
        check("rd_latency", 64'(t_r - t_x), 64'd43);
        check("rd_rdata",   {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
        check("rd_err",     {63'd0, a_if.rsp_err}, 64'd0);
        step();
        check("rd_rsp_width", {63'd0, a_if.rsp_valid}, 64'd0);

        // Single write on B
        busy_len = 5;
        drive_req(1'b1, 1'b1, 16'h0004, 32'h1234_5678, t_x);
        check("wr_start_write", {63'd0, ctrl_start_write}, 64'd1);
        check("wr_start_read",  {63'd0, ctrl_start_read},  64'd0);
        check("wr_ctrl_wdata",  {32'd0, ctrl_wdata},       64'h1234_5678);
        check("wr_ctrl_addr",   {48'd0, ctrl_addr},        64'h0004);
        wait_rsp(1'b1, 100, t_r);
        check("wr_latency", 64'(t_r - t_x), 64'd8);
        check("wr_rdata",   {32'd0, rsp_rdata}, 64'd0);
        check("wr_err",     {63'd0, b_if.rsp_err}, 64'd0);
        step();

        // Contention: both ports request continuously
        busy_len = 3;
        set_req(1'b0, 1'b1, 1'b0, 16'h0100, 32'h0000_0000);
        set_req(1'b1, 1'b1, 1'b0, 16'h0200, 32'h0000_0000);
        for (int i = 0; i < 6; i++) begin
            wait_start(100, t_s);
            check($sformatf("rr_order_%0d", i), {48'd0, ctrl_addr},
                  (i % 2 == 0) ? 64'h0100 : 64'h0200);
            step();
        end
        set_req(1'b0, 1'b0, 1'b0, 16'h0100, 32'h0000_0000);
        set_req(1'b1, 1'b0, 1'b0, 16'h0200, 32'h0000_0000);
        wait_rsp(1'b1, 100, t_r);
        check("rr_last_rdata", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
        step();

        // Timeout: controller never raises busy
        model_dead = 1'b1;
        drive_req(1'b0, 1'b0, 16'h0020, 32'h0000_0000, t_x);
        wait_start(10, t_s);
        check("to_start_lat", 64'(t_s - t_x), 64'd1);
        step();
        wait_rsp(1'b0, 40, t_r);
        check("to_rsp_lat", 64'(t_r - t_s), 64'd8);
        check("to_err",     {63'd0, a_if.rsp_err}, 64'd1);
        check("to_rdata",   {32'd0, rsp_rdata}, 64'd0);
        model_dead = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 16'h0030, 32'h0000_0000);
        step();
        check("to_idle_ready", {63'd0, a_if.ready}, 64'd1);
        step();
        set_req(1'b0, 1'b0, 1'b0, 16'h0030, 32'h0000_0000);
        wait_rsp(1'b0, 100, t_r);
        check("to_next_err",   {63'd0, a_if.rsp_err}, 64'd0);
        check("to_next_rdata", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
        step();

        // Controller busy while idle blocks the grant
        force_busy = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 16'h0060, 32'h0000_0000);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("busy_idle_ready_%0d", i), {63'd0, a_if.ready}, 64'd0);
            step();
        end
        force_busy = 1'b0;
        #1;
        check("busy_drop_ready", {63'd0, a_if.ready}, 64'd1);
        step();
        set_req(1'b0, 1'b0, 1'b0, 16'h0060, 32'h0000_0000);
        check("busy_drop_start", {63'd0, ctrl_start_read}, 64'd1);
        wait_rsp(1'b0, 100, t_r);
        check("busy_drop_err", {63'd0, a_if.rsp_err}, 64'd0);
        step();

        // Reset in WAIT_DONE while the controller is still busy
        busy_len = 20;
        drive_req(1'b0, 1'b0, 16'h0040, 32'h0000_0000, t_x);
        repeat (6) step();
        set_req(1'b1, 1'b1, 1'b1, 16'h0050, 32'hCAFE_F00D);
        a_snap = a_rsp_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_addr", {48'd0, ctrl_addr}, 64'd0);
        viol = 0;
        fell = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!ctrl_busy) begin
                fell = 1'b1;
                break;
            end
            if (b_if.ready || ctrl_start_read || ctrl_start_write ||
                a_if.rsp_valid || b_if.rsp_valid) viol++;
            step();
        end
        check("mid_rst_busy_fell", {63'd0, fell}, 64'd1);
        check("mid_rst_quiet", 64'(viol), 64'd0);
        check("mid_rst_grant_after", {63'd0, b_if.ready}, 64'd1);
        step();
        set_req(1'b1, 1'b0, 1'b1, 16'h0050, 32'hCAFE_F00D);
        check("mid_rst_start_write", {63'd0, ctrl_start_write}, 64'd1);
        check("mid_rst_wdata", {32'd0, ctrl_wdata}, 64'hCAFE_F00D);
        check("mid_rst_addr2", {48'd0, ctrl_addr}, 64'h0050);
        wait_rsp(1'b1, 100, t_r);
        check("mid_rst_err",   {63'd0, b_if.rsp_err}, 64'd0);
        check("mid_rst_rdata", {32'd0, rsp_rdata}, 64'd0);
        step();
        check("mid_rst_no_a_rsp", 64'(a_rsp_cnt - a_snap), 64'd0);
        check("never_both_rsp", 64'(both_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of spi_ram_controller.
- Lets two independent requesters (e.g. LED/display fetch and pattern writer) share one SPI RAM.
- Accepts one request at a time and drives a single start_read/start_write pulse.
- Tracks the controller's busy handshake and returns per-port completion, read data and a timeout error flag.

Parameters:
- ADDR_W, 16, address width; matches spi_ram_controller addr_in.
- DATA_W, 32, data word width; matches data_in/data_out.
- START_WAIT, 8, cycles to wait for busy to rise after a start pulse before flagging a timeout.

Ports:
- clk  in  1  system clock (12 MHz board clock).
- rst  in  1  synchronous active-high reset.
- a_valid  in  1  port A request pending.
- a_write  in  1  port A: 1=write, 0=read.
- a_addr  in  ADDR_W  port A byte address.
- a_wdata  in  DATA_W  port A write data.
- a_ready  out  1  port A request accepted this cycle.
- a_rsp_valid  out  1  port A completion pulse.
- a_rsp_err  out  1  port A timeout flag, qualified by a_rsp_valid.
- b_valid, b_write, b_addr, b_wdata, b_ready, b_rsp_valid, b_rsp_err: same as port A, for port B.
- rsp_rdata  out  DATA_W  read data, shared; qualified by a_rsp_valid or b_rsp_valid.
- ctrl_addr  out  ADDR_W  to controller addr_in.
- ctrl_wdata  out  DATA_W  to controller data_in.
- ctrl_start_read  out  1  one-cycle read start pulse.
- ctrl_start_write  out  1  one-cycle write start pulse.
- ctrl_rdata  in  DATA_W  from controller data_out.
- ctrl_busy  in  1  from controller busy.

Behaviour:
- Reset (rst=1 at clk edge):
  - State = IDLE; last_grant = B, so A wins the first tie.
  - All outputs 0, including ctrl_addr, ctrl_wdata and rsp_rdata.
  - Timeout counter = 0.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE, grant selection:
  - No grant while ctrl_busy=1.
  - Otherwise, if exactly one port is valid, select it.
  - If both are valid, select the port that is not last_grant.
- a_ready/b_ready:
  - Combinational: high only in IDLE, only for the selected port, only while ctrl_busy=0.
  - A request transfers when valid && ready.
- On transfer:
  - Latch addr, wdata, write flag and port ID.
  - ctrl_addr and ctrl_wdata take the latched values and hold until the next transfer.
  - Next state ISSUE.
- Requesters must hold valid and payload stable until ready. The arbiter ignores valid in all states other than IDLE.
- ISSUE: assert exactly one of ctrl_start_read/ctrl_start_write for one cycle. Clear the timeout counter. Next state WAIT_BUSY.
- WAIT_BUSY:
  - ctrl_busy=1 -> WAIT_DONE.
  - Otherwise increment the counter.
  - When the counter reaches START_WAIT-1 with busy still low: set err=1, capture rdata=0, go to RESP.
- WAIT_DONE: when ctrl_busy=0, capture ctrl_rdata for reads (0 for writes), err=0, go to RESP.
- RESP:
  - Pulse x_rsp_valid for the latched port for exactly 1 cycle, with rsp_rdata and x_rsp_err valid.
  - Set last_grant = latched port.
  - Next state IDLE. A new grant is possible the following cycle.
- Latency:
  - Transfer at cycle T -> start pulse at T+1.
  - Busy falling seen at cycle D -> rsp_valid at D+1.
- Minimum issue spacing is one transaction per (controller time + 3) cycles.
- Timing rules:
  - a_rsp_valid and b_rsp_valid are never high simultaneously.
  - A port's ready never rises while its own transaction is outstanding.
- Width: counter is clog2(START_WAIT)+1 bits and saturates (no wrap). START_WAIT >= 2.
- Reset mid-transaction:
  - FSM returns to IDLE; start pulses are 0 the next cycle; no rsp is emitted for the aborted request.
  - The controller's in-flight operation is not aborted. The IDLE no-grant-while-busy rule keeps the arbiter from starting a new request until the controller finishes.
- Simultaneous events:
  - A port that gets rsp_valid may present a new request in the same cycle; it is considered in IDLE on the next cycle.
  - If both ports are valid, the other port wins by round-robin.

Decomposition:
- Shared package spi_ram_pkg holds:
  - SPI_ADDR_W = 16, SPI_DATA_W = 32.
  - State enum values (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP).
  - Port ID constants PORT_A = 0, PORT_B = 1.
- One natural sub-module: rr_arb2, the combinational 2-way round-robin select (inputs: valid_a, valid_b, last_grant, enable; outputs: grant_a, grant_b). The FSM, latches and timeout stay in the top.

Test Plan:
- Single read, A only: addr=0x0010, controller model busy 1 cycle after start for 40 cycles with data 0xDEADBEEF -> one read-start pulse, ctrl_addr=0x0010, a_rsp_valid 1 cycle after busy falls, rsp_rdata=0xDEADBEEF, err=0.
- Single write, B only: addr=0x0004, wdata=0x12345678 -> one write-start pulse, ctrl_wdata=0x12345678, b_rsp_valid, rsp_rdata=0.
- Contention: A and B valid continuously for 6 transactions -> grant order A,B,A,B,A,B; never two rsp_valid together.
- Timeout, START_WAIT=8: busy held low -> start pulse then a_rsp_valid with a_rsp_err=1 exactly 8 cycles after the pulse, FSM back in IDLE.
- Busy at idle: ctrl_busy=1 while A valid -> a_ready stays 0 until busy drops, then a_ready=1 that cycle.
- Reset mid WAIT_DONE: assert rst for 1 cycle with busy high -> no rsp pulse, start pulses 0, no new grant until busy falls; the next request completes normally.
